// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit:
// opcodes, FSM state enum and datapath mux-select values.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_EXEC_I    = 4'd8,
    S_ALU_WB    = 4'd9,
    S_BRANCH    = 4'd10,
    S_JALR      = 4'd11,
    S_LINK      = 4'd12,
    S_LUI       = 4'd13,
    S_TRAP      = 4'd14
  } state_t;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/ctrl_mem_watchdog.sv
// Memory wait watchdog: counts consecutive not-ready cycles.
// Ports: clk, rst_n, clear (state change), waiting, expired.
module ctrl_mem_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  localparam int unsigned CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned LAST =
    (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  logic [CW-1:0] count;

  // Fires on the waiting cycle that would bring the count to
  // TIMEOUT_CYCLES; a ready cycle is never "waiting", so it wins.
  assign expired = (TIMEOUT_CYCLES != 0) && waiting
                   && (count == CW'(LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (waiting) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch..writeback,
// drives datapath selects/enables, traps illegal ops and bus hangs.
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_HANDSHAKE  = 1,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       pc_src,
  output logic       branch,
  output logic       instr_retired,
  output logic       illegal,
  output logic       bus_error,
  output logic [3:0] state_o
);

  state_t state;
  state_t next_state;
  logic   ready;
  logic   waiting;
  logic   expired;
  logic   set_illegal;
  logic   set_bus;

  assign ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

  assign waiting = !ready && ((state == S_FETCH)
                   || (state == S_MEM_READ)
                   || (state == S_MEM_WRITE));

  ctrl_mem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (next_state != state),
    .waiting(waiting),
    .expired(expired)
  );

  always_comb begin
    next_state    = state;
    set_illegal   = 1'b0;
    set_bus       = 1'b0;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALU_ADD;
    result_src    = RES_ALUOUT;
    pc_src        = 1'b0;
    branch        = 1'b0;
    instr_retired = 1'b0;
    unique case (state)
      S_RESET: next_state = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = ready;
        pc_write  = ready;
        if (ready) begin
          next_state = S_DECODE;
        end else if (expired) begin
          next_state = S_TRAP;
          set_bus    = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        unique case (opcode)
          OP_LOAD,
          OP_STORE:  next_state = S_MEM_ADDR;
          OP_R:      next_state = S_EXEC_R;
          OP_I:      next_state = S_EXEC_I;
          OP_BRANCH: next_state = S_BRANCH;
          OP_JAL:    next_state = S_LINK;
          OP_JALR:   next_state = S_JALR;
          OP_LUI:    next_state = S_LUI;
          default: begin
            next_state  = S_TRAP;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        next_state = (opcode == OP_LOAD) ? S_MEM_READ
                                         : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (ready) begin
          next_state = S_MEM_WB;
        end else if (expired) begin
          next_state = S_TRAP;
          set_bus    = 1'b1;
        end
      end
      S_MEM_WB: begin
        reg_write     = 1'b1;
        result_src    = RES_MEM;
        instr_retired = 1'b1;
        next_state    = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write     = 1'b1;
        i_or_d        = 1'b1;
        instr_retired = ready;
        if (ready) begin
          next_state = S_FETCH;
        end else if (expired) begin
          next_state = S_TRAP;
          set_bus    = 1'b1;
        end
      end
      S_EXEC_R: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_FUNCT;
        next_state = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALU_FUNCT;
        next_state = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write     = 1'b1;
        result_src    = RES_ALUOUT;
        instr_retired = 1'b1;
        next_state    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = SRCA_RS1;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALU_BRANCH;
        branch        = 1'b1;
        pc_src        = 1'b1;
        instr_retired = 1'b1;
        next_state    = S_FETCH;
      end
      S_JALR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        next_state = S_LINK;
      end
      S_LINK: begin
        alu_src_a     = SRCA_OLDPC;
        alu_src_b     = SRCB_FOUR;
        reg_write     = 1'b1;
        result_src    = RES_ALU;
        pc_write      = 1'b1;
        pc_src        = 1'b1;
        instr_retired = 1'b1;
        next_state    = S_FETCH;
      end
      S_LUI: begin
        alu_src_a     = SRCA_ZERO;
        alu_src_b     = SRCB_IMM;
        reg_write     = 1'b1;
        result_src    = RES_ALU;
        instr_retired = 1'b1;
        next_state    = S_FETCH;
      end
      S_TRAP: next_state = S_TRAP;
      default: next_state = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RESET;
      illegal   <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      state <= next_state;
      if (set_illegal) illegal <= 1'b1;
      if (set_bus) bus_error <= 1'b1;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle vector
// table plus trap, watchdog and async-reset sequences.
module tb_multicycle_control_unit;
  import riscv_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, reg_write;
  logic       mem_read, mem_write, i_or_d;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic       pc_src, branch, instr_retired;
  logic       illegal, bus_error;
  logic [3:0] state_o;
  logic [16:0] ctrl_act;

  int errs = 0;
  int checks = 0;

  multicycle_control_unit #(
    .MEM_HANDSHAKE (1),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .ir_write     (ir_write),
    .reg_write    (reg_write),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .i_or_d       (i_or_d),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .result_src   (result_src),
    .pc_src       (pc_src),
    .branch       (branch),
    .instr_retired(instr_retired),
    .illegal      (illegal),
    .bus_error    (bus_error),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  assign ctrl_act = {pc_write, ir_write, reg_write, mem_read,
                     mem_write, i_or_d, alu_src_a, alu_src_b,
                     alu_op, result_src, pc_src, branch,
                     instr_retired};

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] JL = 7'b1101111;
  localparam logic [6:0] JR = 7'b1100111;
  localparam logic [6:0] LU = 7'b0110111;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef struct {
    string       nm;
    logic [6:0]  opc;
    logic        rdy;
    logic [3:0]  st;
    logic [16:0] c;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [16:0] cv(
    input logic pw, iw, rw, mr, mw, iod,
    input logic [1:0] a, b, op, rs,
    input logic ps, br, ret);
    return {pw, iw, rw, mr, mw, iod, a, b, op, rs, ps, br, ret};
  endfunction

  logic [16:0] C_F1, C_F0, C_DEC, C_MA, C_MR, C_MWB, C_MW0;
  logic [16:0] C_MW1, C_ER, C_EI, C_AWB, C_BR, C_JR, C_LK;
  logic [16:0] C_LUI;
  logic [16:0] C_Z;

  task automatic add(input string nm, input logic [6:0] o,
                     input logic r, input logic [3:0] s,
                     input logic [16:0] c);
    vec_t v;
    v.nm = nm;
    v.opc = o;
    v.rdy = r;
    v.st = s;
    v.c = c;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [3:0] st,
                     input logic [16:0] c, input logic il,
                     input logic be);
    checks++;
    if (state_o !== st || ctrl_act !== c
        || illegal !== il || bus_error !== be) begin
      errs++;
      $display("FAIL %s: got state=%0d ctrl=%h ill=%b bus=%b want state=%0d ctrl=%h ill=%b bus=%b",
               nm, state_o, ctrl_act, illegal, bus_error,
               st, c, il, be);
    end
  endtask

  // Inputs applied 1ns after posedge, outputs checked 3ns after.
  task automatic cyc(input string nm, input logic [6:0] o,
                     input logic r, input logic [3:0] s,
                     input logic [16:0] c, input logic il,
                     input logic be);
    opcode = o;
    mem_ready = r;
    #2;
    chk(nm, s, c, il, be);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    opcode = '0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("in_reset", S_RESET, C_Z, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    C_Z   = '0;
    C_F1  = cv(1,1,0,1,0,0, 2'd0,2'd2,2'd0,2'd0, 0,0,0);
    C_F0  = cv(0,0,0,1,0,0, 2'd0,2'd2,2'd0,2'd0, 0,0,0);
    C_DEC = cv(0,0,0,0,0,0, 2'd1,2'd1,2'd0,2'd0, 0,0,0);
    C_MA  = cv(0,0,0,0,0,0, 2'd2,2'd1,2'd0,2'd0, 0,0,0);
    C_MR  = cv(0,0,0,1,0,1, 2'd0,2'd0,2'd0,2'd0, 0,0,0);
    C_MWB = cv(0,0,1,0,0,0, 2'd0,2'd0,2'd0,2'd1, 0,0,1);
    C_MW0 = cv(0,0,0,0,1,1, 2'd0,2'd0,2'd0,2'd0, 0,0,0);
    C_MW1 = cv(0,0,0,0,1,1, 2'd0,2'd0,2'd0,2'd0, 0,0,1);
    C_ER  = cv(0,0,0,0,0,0, 2'd2,2'd0,2'd2,2'd0, 0,0,0);
    C_EI  = cv(0,0,0,0,0,0, 2'd2,2'd1,2'd2,2'd0, 0,0,0);
    C_AWB = cv(0,0,1,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,0,1);
    C_BR  = cv(0,0,0,0,0,0, 2'd2,2'd0,2'd1,2'd0, 1,1,1);
    C_JR  = cv(0,0,0,0,0,0, 2'd2,2'd1,2'd0,2'd0, 0,0,0);
    C_LK  = cv(1,0,1,0,0,0, 2'd1,2'd2,2'd0,2'd2, 1,0,1);
    C_LUI = cv(0,0,1,0,0,0, 2'd3,2'd1,2'd0,2'd2, 0,0,1);

    add("rst",     R,  1, S_RESET,     C_Z);
    add("add_f",   R,  1, S_FETCH,     C_F1);
    add("add_d",   R,  1, S_DECODE,    C_DEC);
    add("add_x",   R,  1, S_EXEC_R,    C_ER);
    add("add_wb",  R,  1, S_ALU_WB,    C_AWB);
    add("addi_f",  I,  1, S_FETCH,     C_F1);
    add("addi_d",  I,  1, S_DECODE,    C_DEC);
    add("addi_x",  I,  1, S_EXEC_I,    C_EI);
    add("addi_wb", I,  1, S_ALU_WB,    C_AWB);
    add("lw_f",    LD, 1, S_FETCH,     C_F1);
    add("lw_d",    LD, 1, S_DECODE,    C_DEC);
    add("lw_a",    LD, 1, S_MEM_ADDR,  C_MA);
    add("lw_r0",   LD, 0, S_MEM_READ,  C_MR);
    add("lw_r1",   LD, 0, S_MEM_READ,  C_MR);
    add("lw_r2",   LD, 0, S_MEM_READ,  C_MR);
    add("lw_r3",   LD, 1, S_MEM_READ,  C_MR);
    add("lw_wb",   LD, 1, S_MEM_WB,    C_MWB);
    add("sw_f0",   ST, 0, S_FETCH,     C_F0);
    add("sw_f1",   ST, 1, S_FETCH,     C_F1);
    add("sw_d",    ST, 1, S_DECODE,    C_DEC);
    add("sw_a",    ST, 1, S_MEM_ADDR,  C_MA);
    add("sw_w0",   ST, 0, S_MEM_WRITE, C_MW0);
    add("sw_w1",   ST, 1, S_MEM_WRITE, C_MW1);
    add("beq_f",   BR, 1, S_FETCH,     C_F1);
    add("beq_d",   BR, 1, S_DECODE,    C_DEC);
    add("beq_x",   BR, 1, S_BRANCH,    C_BR);
    add("jal_f",   JL, 1, S_FETCH,     C_F1);
    add("jal_d",   JL, 1, S_DECODE,    C_DEC);
    add("jal_l",   JL, 1, S_LINK,      C_LK);
    add("jalr_f",  JR, 1, S_FETCH,     C_F1);
    add("jalr_d",  JR, 1, S_DECODE,    C_DEC);
    add("jalr_t",  JR, 1, S_JALR,      C_JR);
    add("jalr_l",  JR, 1, S_LINK,      C_LK);
    add("lui_f",   LU, 1, S_FETCH,     C_F1);
    add("lui_d",   LU, 1, S_DECODE,    C_DEC);
    add("lui_x",   LU, 1, S_LUI,       C_LUI);
    add("next_f",  R,  1, S_FETCH,     C_F1);

    #1;
    do_reset();
    foreach (tbl[i])
      cyc(tbl[i].nm, tbl[i].opc, tbl[i].rdy, tbl[i].st,
          tbl[i].c, 1'b0, 1'b0);

    // Illegal opcode: absorbing TRAP with sticky flag.
    do_reset();
    cyc("il_rst", BAD, 1, S_RESET, C_Z, 0, 0);
    cyc("il_f", BAD, 1, S_FETCH, C_F1, 0, 0);
    cyc("il_d", BAD, 1, S_DECODE, C_DEC, 0, 0);
    for (int i = 0; i < 20; i++)
      cyc("il_trap", R, 1'(i % 2), S_TRAP, C_Z, 1, 0);

    // Watchdog expiry: 4 stuck cycles in FETCH.
    do_reset();
    cyc("to_rst", R, 0, S_RESET, C_Z, 0, 0);
    for (int i = 0; i < 4; i++)
      cyc("to_wait", R, 0, S_FETCH, C_F0, 0, 0);
    cyc("to_trap", R, 0, S_TRAP, C_Z, 0, 1);
    cyc("to_hold", R, 1, S_TRAP, C_Z, 0, 1);

    // Ready on the expiring cycle wins.
    do_reset();
    cyc("rs_rst", R, 0, S_RESET, C_Z, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc("rs_wait", R, 0, S_FETCH, C_F0, 0, 0);
    cyc("rs_f1", R, 1, S_FETCH, C_F1, 0, 0);
    cyc("rs_d", R, 1, S_DECODE, C_DEC, 0, 0);
    cyc("rs_x", R, 1, S_EXEC_R, C_ER, 0, 0);
    cyc("rs_wb", R, 1, S_ALU_WB, C_AWB, 0, 0);

    // Async reset during MEM_WRITE.
    do_reset();
    cyc("ar_rst", ST, 1, S_RESET, C_Z, 0, 0);
    cyc("ar_f", ST, 1, S_FETCH, C_F1, 0, 0);
    cyc("ar_d", ST, 1, S_DECODE, C_DEC, 0, 0);
    cyc("ar_a", ST, 1, S_MEM_ADDR, C_MA, 0, 0);
    opcode = ST;
    mem_ready = 1'b0;
    #2;
    chk("ar_w", S_MEM_WRITE, C_MW0, 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_drop", S_RESET, C_Z, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("ar_rst2", ST, 1, S_RESET, C_Z, 0, 0);
    cyc("ar_f2", ST, 1, S_FETCH, C_F1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
